// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: entry layout and instruction kinds, also used by the
// reservation stations and load/store buffer.
package rob_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int ROB_TAG_W = 5;

    typedef enum logic [1:0] {
        REG    = 2'd0,
        BRANCH = 2'd1,
        STORE  = 2'd2
    } rob_kind_e;

    typedef struct packed {
        logic        valid;
        logic        ready;
        rob_kind_e   kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] val;
        logic        mispredict;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / writeback / query / commit bundle between the core and the reorder buffer.
// The master side is the core (frontend, CDB, operand fetch); the slave side is the ROB.
interface reorder_buffer_if #(
    parameter int TAG_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_kind;
    logic [4:0]       issue_rd;
    logic [31:0]      issue_pc;
    logic [TAG_W-1:0] issue_tag;
    logic             dep_set_en;
    logic [4:0]       dep_set_reg;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_val;
    logic             wb_mispredict;
    logic [31:0]      wb_target;

    logic [TAG_W-1:0] qry1_tag;
    logic [TAG_W-1:0] qry2_tag;
    logic             qry1_ready;
    logic             qry2_ready;
    logic [31:0]      qry1_val;
    logic [31:0]      qry2_val;

    logic             commit_en;
    logic [4:0]       commit_id;
    logic [TAG_W-1:0] commit_tag;
    logic [31:0]      commit_val;
    logic             commit_store;
    logic             flush;
    logic [31:0]      redirect_pc;

    modport master (
        output issue_valid, issue_kind, issue_rd, issue_pc,
        output wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
        output qry1_tag, qry2_tag,
        input  issue_ready, issue_tag, dep_set_en, dep_set_reg,
        input  qry1_ready, qry2_ready, qry1_val, qry2_val,
        input  commit_en, commit_id, commit_tag, commit_val, commit_store,
        input  flush, redirect_pc
    );

    modport slave (
        input  issue_valid, issue_kind, issue_rd, issue_pc,
        input  wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
        input  qry1_tag, qry2_tag,
        output issue_ready, issue_tag, dep_set_en, dep_set_reg,
        output qry1_ready, qry2_ready, qry1_val, qry2_val,
        output commit_en, commit_id, commit_tag, commit_val, commit_store,
        output flush, redirect_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, collects CDB results,
// retires one entry per cycle from the head and flushes on a mispredicted branch.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  rob
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    rob_entry_t       ent_q [DEPTH];
    rob_entry_t       ent_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    rob_entry_t head_ent;
    rob_entry_t qry1_ent;
    rob_entry_t qry2_ent;
    logic       full;
    logic       empty;
    logic       commit_fire;
    logic       alloc;
    logic       bypass1;
    logic       bypass2;

    always_comb begin
        head_ent    = ent_q[head_q];
        full        = (count_q == FULL_CNT);
        empty       = (count_q == '0);
        commit_fire = !empty && head_ent.valid && head_ent.ready;

        rob.flush       = commit_fire && (head_ent.kind == BRANCH) && head_ent.mispredict;
        rob.redirect_pc = rob.flush ? head_ent.target : '0;

        // Full blocks issue even when the head retires this cycle: the freed slot is reused next cycle.
        rob.issue_ready = !full && !rob.flush;
        alloc           = rob.issue_valid && rob.issue_ready;
        rob.issue_tag   = tail_q;
        rob.dep_set_en  = alloc && (rob_kind_e'(rob.issue_kind) == REG) && (rob.issue_rd != '0);
        rob.dep_set_reg = rob.dep_set_en ? rob.issue_rd : '0;

        rob.commit_en    = commit_fire && (head_ent.kind == REG);
        rob.commit_id    = rob.commit_en ? head_ent.rd : '0;
        rob.commit_tag   = rob.commit_en ? head_q : '0;
        rob.commit_val   = rob.commit_en ? head_ent.val : '0;
        rob.commit_store = commit_fire && (head_ent.kind == STORE);
    end

    // Operand lookups see a result broadcast on the CDB in the same cycle.
    always_comb begin
        qry1_ent       = ent_q[rob.qry1_tag];
        qry2_ent       = ent_q[rob.qry2_tag];
        bypass1        = rob.wb_valid && (rob.wb_tag == rob.qry1_tag);
        bypass2        = rob.wb_valid && (rob.wb_tag == rob.qry2_tag);
        rob.qry1_ready = qry1_ent.ready || bypass1;
        rob.qry2_ready = qry2_ent.ready || bypass2;
        rob.qry1_val   = bypass1 ? rob.wb_val : qry1_ent.val;
        rob.qry2_val   = bypass2 ? rob.wb_val : qry2_ent.val;
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rob.flush) begin
            // Writeback and issue in the flush cycle are discarded along with the younger entries.
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (rob.wb_valid && ent_q[rob.wb_tag].valid) begin
                ent_d[rob.wb_tag].ready      = 1'b1;
                ent_d[rob.wb_tag].val        = rob.wb_val;
                ent_d[rob.wb_tag].mispredict = rob.wb_mispredict;
                ent_d[rob.wb_tag].target     = rob.wb_target;
            end
            if (commit_fire) begin
                ent_d[head_q].valid = 1'b0;
                head_d              = head_q + 1'b1;
            end
            if (alloc) begin
                ent_d[tail_q] = '{valid: 1'b1, ready: 1'b0,
                                  kind: rob_kind_e'(rob.issue_kind),
                                  rd: rob.issue_rd, pc: rob.issue_pc,
                                  val: '0, mispredict: 1'b0, target: '0};
                tail_d        = tail_q + 1'b1;
            end
            count_d = count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: per-cycle vector table plus hand-written
// sequences for fill/wrap, mispredict flush and asynchronous reset.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reorder_buffer_if #(.TAG_W(5)) rif ();

    reorder_buffer #(.DEPTH(32), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        r;
        logic        iv;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        wv;
        logic [4:0]  wt;
        logic [31:0] wval;
        logic [4:0]  q1;
        logic [4:0]  q2;
    } in_t;

    typedef struct packed {
        logic        ir;
        logic [4:0]  itag;
        logic        dse;
        logic [4:0]  dsr;
        logic        cen;
        logic [4:0]  cid;
        logic [4:0]  ctag;
        logic [31:0] cval;
        logic        cst;
        logic        fl;
        logic [31:0] rpc;
        logic        q1r;
        logic [31:0] q1v;
        logic        q2r;
        logic [31:0] q2v;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    function automatic in_t mi(logic r, logic iv, logic [1:0] kind, logic [4:0] rd,
                               logic [31:0] pc, logic wv, logic [4:0] wt,
                               logic [31:0] wval, logic [4:0] q1);
        in_t x;
        x.r = r; x.iv = iv; x.kind = kind; x.rd = rd; x.pc = pc;
        x.wv = wv; x.wt = wt; x.wval = wval; x.q1 = q1; x.q2 = 5'd31;
        return x;
    endfunction

    // Flush/mispredict are covered by a hand sequence, so table rows expect them low.
    function automatic out_t mo(logic [4:0] itag, logic dse, logic [4:0] dsr,
                                logic cen, logic [4:0] cid, logic [4:0] ctag,
                                logic [31:0] cval, logic cst, logic q1r, logic [31:0] q1v);
        out_t x;
        x.ir = 1'b1; x.itag = itag; x.dse = dse; x.dsr = dsr;
        x.cen = cen; x.cid = cid; x.ctag = ctag; x.cval = cval; x.cst = cst;
        x.fl = 1'b0; x.rpc = '0; x.q1r = q1r; x.q1v = q1v; x.q2r = 1'b0; x.q2v = '0;
        return x;
    endfunction

    function automatic out_t sample();
        out_t x;
        x.ir = rif.issue_ready; x.itag = rif.issue_tag;
        x.dse = rif.dep_set_en; x.dsr = rif.dep_set_reg;
        x.cen = rif.commit_en; x.cid = rif.commit_id; x.ctag = rif.commit_tag;
        x.cval = rif.commit_val; x.cst = rif.commit_store;
        x.fl = rif.flush; x.rpc = rif.redirect_pc;
        x.q1r = rif.qry1_ready; x.q1v = rif.qry1_val;
        x.q2r = rif.qry2_ready; x.q2v = rif.qry2_val;
        return x;
    endfunction

    task automatic set_idle();
        rif.issue_valid = 1'b0; rif.issue_kind = 2'd0; rif.issue_rd = '0; rif.issue_pc = '0;
        rif.wb_valid = 1'b0; rif.wb_tag = '0; rif.wb_val = '0;
        rif.wb_mispredict = 1'b0; rif.wb_target = '0;
        rif.qry1_tag = 5'd30; rif.qry2_tag = 5'd31;
    endtask

    task automatic issue(logic [1:0] kind, logic [4:0] rd, logic [31:0] pc);
        rif.issue_valid = 1'b1; rif.issue_kind = kind; rif.issue_rd = rd; rif.issue_pc = pc;
    endtask

    task automatic wb(logic [4:0] tag, logic [31:0] val, logic mis, logic [31:0] tgt);
        rif.wb_valid = 1'b1; rif.wb_tag = tag; rif.wb_val = val;
        rif.wb_mispredict = mis; rif.wb_target = tgt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        out_t act;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_idle();

        //            r  iv kind rd  pc          wv wt  wval          q1
        tbl[0]  = '{mi(1, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd30), mo(0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[1]  = '{mi(0, 1, 2'd0, 5, 32'h100,   0, 0,  32'h0,     5'd30), mo(0, 1, 5, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[2]  = '{mi(0, 0, 2'd0, 0, 32'h0,     1, 0,  32'h1234,  5'd0),  mo(1, 0, 0, 0, 0, 0, 32'h0,    0, 1, 32'h1234)};
        tbl[3]  = '{mi(0, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd0),  mo(1, 0, 0, 1, 5, 0, 32'h1234, 0, 1, 32'h1234)};
        tbl[4]  = '{mi(1, 1, 2'd0, 1, 32'h104,   0, 0,  32'h0,     5'd30), mo(0, 1, 1, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[5]  = '{mi(0, 1, 2'd0, 2, 32'h108,   0, 0,  32'h0,     5'd30), mo(1, 1, 2, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[6]  = '{mi(0, 1, 2'd0, 3, 32'h10c,   0, 0,  32'h0,     5'd30), mo(2, 1, 3, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[7]  = '{mi(0, 0, 2'd0, 0, 32'h0,     1, 2,  32'h22,    5'd2),  mo(3, 0, 0, 0, 0, 0, 32'h0,    0, 1, 32'h22)};
        tbl[8]  = '{mi(0, 0, 2'd0, 0, 32'h0,     1, 1,  32'h11,    5'd2),  mo(3, 0, 0, 0, 0, 0, 32'h0,    0, 1, 32'h22)};
        tbl[9]  = '{mi(0, 0, 2'd0, 0, 32'h0,     1, 0,  32'h10,    5'd30), mo(3, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[10] = '{mi(0, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd30), mo(3, 0, 0, 1, 1, 0, 32'h10,   0, 0, 32'h0)};
        tbl[11] = '{mi(0, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd30), mo(3, 0, 0, 1, 2, 1, 32'h11,   0, 0, 32'h0)};
        tbl[12] = '{mi(0, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd30), mo(3, 0, 0, 1, 3, 2, 32'h22,   0, 0, 32'h0)};
        tbl[13] = '{mi(0, 1, 2'd2, 0, 32'h200,   0, 0,  32'h0,     5'd30), mo(3, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[14] = '{mi(0, 1, 2'd0, 0, 32'h204,   1, 3,  32'h7,     5'd3),  mo(4, 0, 0, 0, 0, 0, 32'h0,    0, 1, 32'h7)};
        tbl[15] = '{mi(0, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd3),  mo(5, 0, 0, 0, 0, 0, 32'h0,    1, 1, 32'h7)};
        tbl[16] = '{mi(0, 0, 2'd0, 0, 32'h0,     1, 4,  32'h44,    5'd30), mo(5, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0)};
        tbl[17] = '{mi(0, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd30), mo(5, 0, 0, 1, 0, 4, 32'h44,   0, 0, 32'h0)};
        tbl[18] = '{mi(0, 0, 2'd0, 0, 32'h0,     1, 9,  32'h99,    5'd9),  mo(5, 0, 0, 0, 0, 0, 32'h0,    0, 1, 32'h99)};
        tbl[19] = '{mi(0, 0, 2'd0, 0, 32'h0,     0, 0,  32'h0,     5'd9),  mo(5, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0)};

        for (int n = 0; n < NVEC; n++) begin
            @(negedge clk);
            set_idle();
            if (tbl[n].i.r) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            rif.issue_valid = tbl[n].i.iv;
            rif.issue_kind  = tbl[n].i.kind;
            rif.issue_rd    = tbl[n].i.rd;
            rif.issue_pc    = tbl[n].i.pc;
            rif.wb_valid    = tbl[n].i.wv;
            rif.wb_tag      = tbl[n].i.wt;
            rif.wb_val      = tbl[n].i.wval;
            rif.qry1_tag    = tbl[n].i.q1;
            rif.qry2_tag    = tbl[n].i.q2;
            #1;
            act = sample();
            checks++;
            if (act !== tbl[n].o) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", n, act, tbl[n].o);
            end
        end

        // Fill all 32 slots, then retire the head and check the tag wraps to 0.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            set_idle();
            issue(2'd0, 5'(i % 31 + 1), 32'h1000 + 32'(i * 4));
            #2;
            chk("fill_tag", 32'(rif.issue_tag), 32'(i));
        end
        @(negedge clk);
        set_idle();
        issue(2'd0, 5'd9, 32'h2000);
        #2;
        chk("full_issue_ready", 32'(rif.issue_ready), 32'd0);
        chk("full_dep_set_en", 32'(rif.dep_set_en), 32'd0);
        @(negedge clk);
        set_idle();
        issue(2'd0, 5'd9, 32'h2000);
        wb(5'd0, 32'hAB, 1'b0, 32'h0);
        #2;
        chk("full_wb_no_commit", 32'(rif.commit_en), 32'd0);
        @(negedge clk);
        set_idle();
        issue(2'd0, 5'd9, 32'h2000);
        #2;
        chk("full_commit_en", 32'(rif.commit_en), 32'd1);
        chk("full_commit_id", 32'(rif.commit_id), 32'd1);
        chk("full_commit_val", rif.commit_val, 32'hAB);
        chk("full_commit_ready", 32'(rif.issue_ready), 32'd0);
        @(negedge clk);
        set_idle();
        issue(2'd0, 5'd9, 32'h2000);
        #2;
        chk("wrap_ready", 32'(rif.issue_ready), 32'd1);
        chk("wrap_tag", 32'(rif.issue_tag), 32'd0);
        chk("wrap_dep_set", 32'(rif.dep_set_en), 32'd1);
        @(negedge clk);
        set_idle();
        #2;
        chk("refull_ready", 32'(rif.issue_ready), 32'd0);
        chk("refull_tag", 32'(rif.issue_tag), 32'd1);

        // Mispredicted branch at the head flushes the younger, already-completed REG.
        do_reset();
        @(negedge clk);
        set_idle();
        issue(2'd1, 5'd0, 32'h40);
        #2;
        chk("br_tag", 32'(rif.issue_tag), 32'd0);
        chk("br_dep_set", 32'(rif.dep_set_en), 32'd0);
        @(negedge clk);
        set_idle();
        issue(2'd0, 5'd7, 32'h44);
        #2;
        chk("br_reg_tag", 32'(rif.issue_tag), 32'd1);
        @(negedge clk);
        set_idle();
        wb(5'd1, 32'h5, 1'b0, 32'h0);
        @(negedge clk);
        set_idle();
        wb(5'd0, 32'h0, 1'b1, 32'h80);
        #2;
        chk("pre_flush", 32'(rif.flush), 32'd0);
        @(negedge clk);
        set_idle();
        issue(2'd0, 5'd4, 32'h48);
        wb(5'd1, 32'h66, 1'b0, 32'h0);
        #2;
        chk("flush", 32'(rif.flush), 32'd1);
        chk("redirect_pc", rif.redirect_pc, 32'h80);
        chk("flush_issue_ready", 32'(rif.issue_ready), 32'd0);
        chk("flush_dep_set", 32'(rif.dep_set_en), 32'd0);
        chk("flush_commit_en", 32'(rif.commit_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_idle();
            #2;
            chk("post_flush_flush", 32'(rif.flush), 32'd0);
            chk("post_flush_commit", 32'(rif.commit_en), 32'd0);
            chk("post_flush_tag", 32'(rif.issue_tag), 32'd0);
            chk("post_flush_ready", 32'(rif.issue_ready), 32'd1);
        end
        @(negedge clk);
        set_idle();
        issue(2'd0, 5'd8, 32'h80);
        #2;
        chk("post_flush_issue_tag", 32'(rif.issue_tag), 32'd0);
        @(negedge clk);
        set_idle();
        wb(5'd0, 32'h77, 1'b0, 32'h0);
        @(negedge clk);
        set_idle();
        #2;
        chk("post_flush_commit_id", 32'(rif.commit_id), 32'd8);
        chk("post_flush_commit_val", rif.commit_val, 32'h77);

        // Asynchronous reset with four pending entries and a commit in progress.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_idle();
            issue(2'd0, 5'(i + 10), 32'h300 + 32'(i * 4));
        end
        @(negedge clk);
        set_idle();
        wb(5'd0, 32'h5, 1'b0, 32'h0);
        @(negedge clk);
        set_idle();
        rif.qry1_tag = 5'd0;
        #2;
        chk("pre_rst_commit", 32'(rif.commit_en), 32'd1);
        chk("pre_rst_tag", 32'(rif.issue_tag), 32'd4);
        rst = 1'b1;
        #1;
        chk("rst_issue_tag", 32'(rif.issue_tag), 32'd0);
        chk("rst_issue_ready", 32'(rif.issue_ready), 32'd1);
        chk("rst_commit_en", 32'(rif.commit_en), 32'd0);
        chk("rst_commit_val", rif.commit_val, 32'd0);
        chk("rst_qry1_ready", 32'(rif.qry1_ready), 32'd0);
        chk("rst_flush", 32'(rif.flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        issue(2'd0, 5'd6, 32'h400);
        #2;
        chk("after_rst_tag", 32'(rif.issue_tag), 32'd0);
        @(negedge clk);
        set_idle();
        #2;
        chk("after_rst_tag1", 32'(rif.issue_tag), 32'd1);
        chk("after_rst_commit", 32'(rif.commit_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
